// File: rtl/trim_pkg.sv
// Shared definitions for the gain-trim datapath: widths, FSM encoding and the
// round/saturate helper used wherever a magnitude x gain product is narrowed.
package trim_pkg;

  localparam int TRIM_MAG_WIDTH  = 26;
  localparam int TRIM_GAIN_WIDTH = 27;
  localparam int PRODUCT_WIDTH   = TRIM_MAG_WIDTH + TRIM_GAIN_WIDTH;
  localparam int OVERRUN_WIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_PUBLISH = 2'd3
  } trim_state_t;

  // Gain 1.0 sits at bit GAIN_WIDTH-1, so the magnitude-scaled result starts
  // there; the bit below it is the half-LSB used for round-half-up. A set top
  // product bit or a carry out of the rounding add clamps to all-ones.
  function automatic logic [TRIM_MAG_WIDTH-1:0] round_saturate(
    input logic [PRODUCT_WIDTH-1:0] product
  );
    logic [TRIM_MAG_WIDTH:0] sum;
    sum = {1'b0, product[TRIM_GAIN_WIDTH-1 +: TRIM_MAG_WIDTH]}
        + {{TRIM_MAG_WIDTH{1'b0}}, product[TRIM_GAIN_WIDTH-2]};
    if (product[PRODUCT_WIDTH-1] || sum[TRIM_MAG_WIDTH]) begin
      return '1;
    end
    return sum[TRIM_MAG_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/trim_sequencer_multiplier.sv
// Pipelined unsigned multiplier. The product of operands presented before an
// edge appears on p after NUM_PIPELINE_LEVELS edges. No reset: the contents
// are qualified by the caller's tag pipeline.
module fullMultiplier #(
  parameter int A_WIDTH             = 26,
  parameter int B_WIDTH             = 27,
  parameter int NUM_PIPELINE_LEVELS = 6
) (
  input  logic                       clk,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic [A_WIDTH+B_WIDTH-1:0] p
);

  logic [A_WIDTH+B_WIDTH-1:0] pipe [NUM_PIPELINE_LEVELS];

  // Multiply into the first stage, then delay through the remaining stages.
  always_ff @(posedge clk) begin
    pipe[0] <= (A_WIDTH+B_WIDTH)'(a) * (A_WIDTH+B_WIDTH)'(b);
    for (int i = 1; i < NUM_PIPELINE_LEVELS; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign p = pipe[NUM_PIPELINE_LEVELS-1];

endmodule

// File: rtl/trim_sequencer.sv
// Time-multiplexed gain trim: a strobe latches NUM_GAINS magnitude/gain pairs,
// which are fed one per cycle through a single shared multiplier. Rounded
// results collect in a shadow register and are published together with a
// toggle, so trimmed never shows a partial batch.
// Handshake: strobe is a one-cycle pulse with no back-pressure; it is
// accepted only while busy is low, otherwise it is dropped and counted.
module trim_sequencer
  import trim_pkg::*;
#(
  parameter int NUM_GAINS          = 4,
  parameter int MAG_WIDTH          = TRIM_MAG_WIDTH,   // round_saturate is sized to these
  parameter int GAIN_WIDTH         = TRIM_GAIN_WIDTH,
  parameter int MULTIPLIER_LATENCY = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           strobe,
  input  logic [MAG_WIDTH*NUM_GAINS-1:0]  magnitudes,
  input  logic [GAIN_WIDTH*NUM_GAINS-1:0] gains,
  output logic [MAG_WIDTH*NUM_GAINS-1:0]  trimmed,
  output logic                           trimmedToggle,
  output logic                           busy,
  output logic [OVERRUN_WIDTH-1:0]       overrunCount,
  output logic [1:0]                     fsm_state
);

  localparam int IDX_W = $clog2(NUM_GAINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GAINS - 1);

  trim_state_t state, state_next;

  logic [MAG_WIDTH*NUM_GAINS-1:0]  mag_hold;
  logic [GAIN_WIDTH*NUM_GAINS-1:0] gain_hold;
  logic [MAG_WIDTH*NUM_GAINS-1:0]  shadow;
  logic [IDX_W-1:0]                issue_idx;

  logic [MULTIPLIER_LATENCY-1:0] tag_valid;
  logic [IDX_W-1:0]              tag_idx [MULTIPLIER_LATENCY];
  logic                          tag_out_valid;
  logic [IDX_W-1:0]              tag_out_idx;

  logic accept, issue_en, publish;

  logic [MAG_WIDTH-1:0]            mult_a;
  logic [GAIN_WIDTH-1:0]           mult_b;
  logic [MAG_WIDTH+GAIN_WIDTH-1:0] mult_p;
  logic [MAG_WIDTH-1:0]            rounded;

  assign tag_out_valid = tag_valid[MULTIPLIER_LATENCY-1];
  assign tag_out_idx   = tag_idx[MULTIPLIER_LATENCY-1];
  assign fsm_state     = state;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next-state: issue every channel, wait for the last tag, publish.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (strobe) state_next = ST_ISSUE;
      ST_ISSUE:   if (issue_idx == LAST_IDX) state_next = ST_DRAIN;
      ST_DRAIN:   if (tag_out_valid && tag_out_idx == LAST_IDX) state_next = ST_PUBLISH;
      ST_PUBLISH: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: busy covers everything but IDLE, including the publish cycle.
  always_comb begin
    accept   = 1'b0;
    issue_en = 1'b0;
    publish  = 1'b0;
    busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        busy   = 1'b0;
        accept = strobe;
      end
      ST_ISSUE:   issue_en = 1'b1;
      ST_PUBLISH: publish  = 1'b1;
      default:    ;
    endcase
  end

  // Operand holding registers and issue index; inputs are ignored mid-batch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_hold  <= '0;
      gain_hold <= '0;
      issue_idx <= '0;
    end else if (accept) begin
      mag_hold  <= magnitudes;
      gain_hold <= gains;
      issue_idx <= '0;
    end else if (issue_en) begin
      issue_idx <= issue_idx + 1'b1;
    end
  end

  assign mult_a = mag_hold[32'(issue_idx) * MAG_WIDTH +: MAG_WIDTH];
  assign mult_b = gain_hold[32'(issue_idx) * GAIN_WIDTH +: GAIN_WIDTH];

  fullMultiplier #(
    .A_WIDTH             (MAG_WIDTH),
    .B_WIDTH             (GAIN_WIDTH),
    .NUM_PIPELINE_LEVELS (MULTIPLIER_LATENCY)
  ) u_mult (
    .clk (clk),
    .a   (mult_a),
    .b   (mult_b),
    .p   (mult_p)
  );

  assign rounded = round_saturate(mult_p);

  // Tag pipeline tracks which channel, if any, is leaving the multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < MULTIPLIER_LATENCY; i++) tag_idx[i] <= '0;
    end else begin
      tag_valid  <= {tag_valid[MULTIPLIER_LATENCY-2:0], issue_en};
      tag_idx[0] <= issue_idx;
      for (int i = 1; i < MULTIPLIER_LATENCY; i++) tag_idx[i] <= tag_idx[i-1];
    end
  end

  // Shadow register collects each rounded product in its channel slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (tag_out_valid) begin
      shadow[32'(tag_out_idx) * MAG_WIDTH +: MAG_WIDTH] <= rounded;
    end
  end

  // Publish the complete batch in one edge and flip the completion toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trimmed       <= '0;
      trimmedToggle <= 1'b0;
    end else if (publish) begin
      trimmed       <= shadow;
      trimmedToggle <= ~trimmedToggle;
    end
  end

  // Count strobes dropped while busy, holding at the maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrunCount <= '0;
    end else if (strobe && busy && overrunCount != '1) begin
      overrunCount <= overrunCount + OVERRUN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_trim_sequencer.sv
// Bench for trim_sequencer: directed batches from the test plan followed by
// randomized batches with random spacing, checked against an arithmetic model.
module tb_trim_sequencer;

  localparam int N       = 4;
  localparam int M       = 26;
  localparam int G       = 27;
  localparam int L       = 6;
  localparam int MW      = M * N;
  localparam int GW      = G * N;
  localparam int PUB_LAT = N + L + 1;
  localparam int SPACING = N + L + 2;
  localparam longint unsigned MAG_MAX = (64'd1 << M) - 1;

  logic          clk;
  logic          rst_n;
  logic          strobe;
  logic [MW-1:0] magnitudes;
  logic [GW-1:0] gains;
  logic [MW-1:0] trimmed;
  logic          trimmedToggle;
  logic          busy;
  logic [15:0]   overrunCount;
  logic [1:0]    fsm_state;

  trim_sequencer #(
    .NUM_GAINS          (N),
    .MAG_WIDTH          (M),
    .GAIN_WIDTH         (G),
    .MULTIPLIER_LATENCY (L)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .strobe        (strobe),
    .magnitudes    (magnitudes),
    .gains         (gains),
    .trimmed       (trimmed),
    .trimmedToggle (trimmedToggle),
    .busy          (busy),
    .overrunCount  (overrunCount),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            tests = 0;
  int            fails = 0;
  int            last_t0 = 0;
  bit            have_last = 0;
  int            exp_ovr = 0;
  logic          prev_tog = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: round-half-up of m*g/2^(G-1), clamped to the magnitude range.
  function automatic logic [MW-1:0] model(input logic [MW-1:0] m, input logic [GW-1:0] g);
    logic [MW-1:0] res;
    longint unsigned p, r;
    res = '0;
    for (int i = 0; i < N; i++) begin
      p = longint'(m[i*M +: M]) * longint'(g[i*G +: G]);
      r = (p + (64'd1 << (G - 2))) >> (G - 1);
      if (r > MAG_MAX) r = MAG_MAX;
      res[i*M +: M] = r[M-1:0];
    end
    return res;
  endfunction

  function automatic logic [MW-1:0] pack_m(input int unsigned a, b, c, d);
    return {M'(d), M'(c), M'(b), M'(a)};
  endfunction

  function automatic logic [MW-1:0] rand_m();
    logic [MW-1:0] v;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) v[i*M +: M] = '1;
      else v[i*M +: M] = M'($urandom_range(0, 32'h3FFFFFF));
    end
    return v;
  endfunction

  function automatic logic [GW-1:0] rand_g();
    logic [GW-1:0] v;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 2))
        0:       v[i*G +: G] = G'($urandom_range(0, 32'h7FFFFFF));
        1:       v[i*G +: G] = G'($urandom_range(32'h3FFFC00, 32'h4000400));
        default: v[i*G +: G] = G'($urandom_range(0, 32'h4000000));
      endcase
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse strobe for one edge; returns at the negedge after that edge (t0).
  task automatic send(input logic [MW-1:0] m, input logic [GW-1:0] g, output int t0);
    @(negedge clk);
    magnitudes = m;
    gains      = g;
    strobe     = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    t0 = cyc;
    if (!have_last || (t0 - last_t0) >= SPACING) begin
      exp_q.push_back(model(m, g));
      exp_cyc_q.push_back(t0 + PUB_LAT);
      last_t0   = t0;
      have_last = 1'b1;
    end else if (exp_ovr < 16'hFFFF) begin
      exp_ovr++;
    end
    // Scramble inputs right away: the batch must use the latched operands.
    magnitudes = rand_m();
    gains      = rand_g();
  endtask

  task automatic drain();
    int budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tog = 1'b0;
    end else if (trimmedToggle !== prev_tog) begin
      prev_tog = trimmedToggle;
      if (exp_q.size() == 0) begin
        check("unexpected_publish", 128'(trimmedToggle), 128'(~trimmedToggle));
      end else begin
        check("trimmed", 128'(trimmed), 128'(exp_q.pop_front()));
        check("publish_cycle", 128'(cyc), 128'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int t_dummy;
    rst_n      = 1'b0;
    strobe     = 1'b0;
    magnitudes = '0;
    gains      = '0;
    repeat (3) @(negedge clk);
    check("reset_trimmed", 128'(trimmed), 128'd0);
    check("reset_toggle", 128'(trimmedToggle), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_overrun", 128'(overrunCount), 128'd0);
    check("reset_state", 128'(fsm_state), 128'd0);
    rst_n = 1'b1;
    idle(2);

    // Unity gain with timing checks on busy and the toggle.
    send(pack_m(100, 2000, 3, 32'h3FFFFFF), {N{G'(32'h4000000)}}, t0);
    check("busy_after_strobe", 128'(busy), 128'd1);
    idle(PUB_LAT - 1);
    check("busy_before_publish", 128'(busy), 128'd1);
    check("toggle_before_publish", 128'(trimmedToggle), 128'd0);
    idle(1);
    check("busy_after_publish", 128'(busy), 128'd0);
    check("toggle_after_publish", 128'(trimmedToggle), 128'd1);
    check("unity_passthrough", 128'(trimmed), 128'(pack_m(100, 2000, 3, 32'h3FFFFFF)));
    drain();

    // Rounding at gain 0.5: half rounds up.
    send(pack_m(1, 3, 5, 6), {N{G'(32'h2000000)}}, t0);
    drain();
    check("round_half_up", 128'(trimmed), 128'(pack_m(1, 2, 3, 3)));

    // Saturation on channel 0 only.
    send(pack_m(32'h3FFFFFF, 10, 20, 30),
         {G'(32'h4000000), G'(32'h4000000), G'(32'h4000000), G'(32'h7FFFFFF)}, t0);
    drain();
    check("saturate", 128'(trimmed), 128'(pack_m(32'h3FFFFFF, 10, 20, 30)));

    // Overrun: strobes at t0, t0+4 (dropped), t0+12 (accepted).
    send(rand_m(), rand_g(), t0);
    idle(2);
    send(rand_m(), rand_g(), t_dummy);
    idle(6);
    send(rand_m(), rand_g(), t_dummy);
    check("overrun_spacing", 128'(t_dummy - t0), 128'(SPACING));
    drain();
    check("overrun_count", 128'(overrunCount), 128'(exp_ovr));
    check("overrun_expected_one", 128'(exp_ovr), 128'd1);

    // Async reset mid-batch, then a clean batch.
    send(rand_m(), rand_g(), t0);
    idle(4);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    have_last = 1'b0;
    exp_ovr   = 0;
    #1;
    check("async_rst_trimmed", 128'(trimmed), 128'd0);
    check("async_rst_toggle", 128'(trimmedToggle), 128'd0);
    check("async_rst_busy", 128'(busy), 128'd0);
    check("async_rst_overrun", 128'(overrunCount), 128'd0);
    idle(2);
    rst_n = 1'b1;
    send(pack_m(7, 8, 9, 10), {N{G'(32'h4000000)}}, t0);
    drain();
    check("post_reset_batch", 128'(trimmed), 128'(pack_m(7, 8, 9, 10)));

    // Randomized batches with random spacing (some overrun).
    for (int k = 0; k < 40; k++) begin
      send(rand_m(), rand_g(), t_dummy);
      idle($urandom_range(0, 14));
    end
    drain();
    check("random_overrun_count", 128'(overrunCount), 128'(exp_ovr));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
